// File: rtl/adder_mon_pkg.sv
// Shared types and default widths for the adder result monitor.
package adder_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int N_DEF  = 64;
  localparam int CW_DEF = 32;

endpackage

// File: rtl/adder_result_monitor_if.sv
// Sample input stream and checked-result output stream of the adder result monitor.
interface adder_result_monitor_if
  import adder_mon_pkg::*;
#(
  parameter int N = N_DEF
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] inp1;
  logic [N-1:0] inp2;
  logic [N-1:0] sum;
  logic         cout;
  logic [N-1:0] sumk;
  logic         coutk;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_mismatch;

  modport master (
    output in_valid, inp1, inp2, sum, cout, sumk, coutk, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_mismatch
  );

  modport slave (
    input  in_valid, inp1, inp2, sum, cout, sumk, coutk, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_mismatch
  );

endinterface

// File: rtl/adder_mon_sat_counter.sv
// Saturating up-counter; clr wins over inc and the count never wraps.
module adder_mon_sat_counter #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MAX = {CW{1'b1}};

  logic [CW-1:0] cnt_r;

  // Count register with saturation at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (inc && (cnt_r != MAX)) begin
      cnt_r <= cnt_r + ONE;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/adder_result_monitor.sv
// Checks two adder implementations against a golden sum through a 2-stage stream pipeline.
// Optional first-failure operand capture is enabled by defining ADDER_MON_FAIL_CAPTURE_EN.
module adder_result_monitor
  import adder_mon_pkg::*;
#(
  parameter int N           = N_DEF,
  parameter int CW          = CW_DEF,
  parameter int HALT_ON_ERR = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  adder_result_monitor_if.slave  bus,
  output logic                   err_sticky,
  output logic [CW-1:0]          sample_cnt,
  output logic [CW-1:0]          mismatch_cnt,
`ifdef ADDER_MON_FAIL_CAPTURE_EN
  output logic [N-1:0]           first_fail_a,
  output logic [N-1:0]           first_fail_b,
`endif
  output logic [1:0]             state
);

  state_t       state_r, state_nxt;
  logic         s1_valid_r;
  logic [N-1:0] s1_a_r, s1_b_r, s1_sum_r, s1_sumk_r;
  logic         s1_cout_r, s1_coutk_r;
  logic         out_valid_r, out_cout_r, out_ovf_r, out_mismatch_r;
  logic [N-1:0] out_sum_r;
  logic         err_sticky_r;
  logic         advance_s, accept_s, enter_s2_s, fail_s;
  logic [N-1:0] g_sum_s;
  logic         g_cout_s, ovf_s, mism_s;

  // The whole pipeline moves together whenever the output register can be refilled
  assign advance_s     = !out_valid_r || bus.out_ready;
  assign bus.in_ready  = advance_s && (state_r == RUN);
  assign accept_s      = bus.in_valid && bus.in_ready;
  assign enter_s2_s    = advance_s && s1_valid_r;
  assign fail_s        = enter_s2_s && mism_s;

  // Golden sum, signed overflow and disagreement of either implementation
  always_comb begin
    {g_cout_s, g_sum_s} = {1'b0, s1_a_r} + {1'b0, s1_b_r};
    ovf_s  = (s1_a_r[N-1] == s1_b_r[N-1]) && (g_sum_s[N-1] != s1_a_r[N-1]);
    mism_s = (s1_sum_r != g_sum_s) || (s1_cout_r != g_cout_s) ||
             (s1_sumk_r != g_sum_s) || (s1_coutk_r != g_cout_s);
  end

  // S1: capture of the accepted sample, held while the output stalls
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {N{1'b0}};
      s1_b_r     <= {N{1'b0}};
      s1_sum_r   <= {N{1'b0}};
      s1_sumk_r  <= {N{1'b0}};
      s1_cout_r  <= 1'b0;
      s1_coutk_r <= 1'b0;
    end else if (advance_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_a_r     <= bus.inp1;
        s1_b_r     <= bus.inp2;
        s1_sum_r   <= bus.sum;
        s1_sumk_r  <= bus.sumk;
        s1_cout_r  <= bus.cout;
        s1_coutk_r <= bus.coutk;
      end
    end
  end

  // S2: checked result register driving the output stream
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      out_valid_r    <= 1'b0;
      out_sum_r      <= {N{1'b0}};
      out_cout_r     <= 1'b0;
      out_ovf_r      <= 1'b0;
      out_mismatch_r <= 1'b0;
    end else if (advance_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_sum_r      <= g_sum_s;
        out_cout_r     <= g_cout_s;
        out_ovf_r      <= ovf_s;
        out_mismatch_r <= mism_s;
      end
    end
  end

  // Sticky error flag, raised together with the mismatch counter
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_sticky_r <= 1'b0;
    end else if (fail_s) begin
      err_sticky_r <= 1'b1;
    end
  end

`ifdef ADDER_MON_FAIL_CAPTURE_EN
  logic [N-1:0] ff_a_r, ff_b_r;

  // Operands of the first mismatching sample since the last rst/clr
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ff_a_r <= {N{1'b0}};
      ff_b_r <= {N{1'b0}};
    end else if (fail_s && !err_sticky_r) begin
      ff_a_r <= s1_a_r;
      ff_b_r <= s1_b_r;
    end
  end

  assign first_fail_a = ff_a_r;
  assign first_fail_b = ff_b_r;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next state; clr overrides everything, HALT is left only via clr/rst
  always_comb begin
    state_nxt = state_r;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (en) state_nxt = RUN;
          else    state_nxt = IDLE;
        end
        RUN: begin
          if ((HALT_ON_ERR != 0) && fail_s) state_nxt = HALT;
          else                              state_nxt = RUN;
        end
        HALT:    state_nxt = HALT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  adder_mon_sat_counter #(.CW(CW)) u_sample_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (enter_s2_s),
    .cnt (sample_cnt)
  );

  adder_mon_sat_counter #(.CW(CW)) u_mismatch_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (fail_s),
    .cnt (mismatch_cnt)
  );

  assign bus.out_valid    = out_valid_r;
  assign bus.out_sum      = out_sum_r;
  assign bus.out_cout     = out_cout_r;
  assign bus.out_ovf      = out_ovf_r;
  assign bus.out_mismatch = out_mismatch_r;
  assign err_sticky       = err_sticky_r;
  assign state            = state_r;

endmodule

// File: tb/tb_adder_result_monitor.sv
// Directed self-checking bench for adder_result_monitor (N=64, CW=4, HALT_ON_ERR=1).
module tb_adder_result_monitor;

  logic        clk, rst, en, clr;
  logic        err_sticky;
  logic [3:0]  sample_cnt, mismatch_cnt;
  logic [1:0]  state;
`ifdef ADDER_MON_FAIL_CAPTURE_EN
  logic [63:0] first_fail_a, first_fail_b;
`endif
  int total, bad;

  adder_result_monitor_if #(.N(64)) bus ();

  adder_result_monitor #(.N(64), .CW(4), .HALT_ON_ERR(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clr          (clr),
    .bus          (bus),
    .err_sticky   (err_sticky),
    .sample_cnt   (sample_cnt),
    .mismatch_cnt (mismatch_cnt),
`ifdef ADDER_MON_FAIL_CAPTURE_EN
    .first_fail_a (first_fail_a),
    .first_fail_b (first_fail_b),
`endif
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [63:0] s,
                       input logic c, input logic [63:0] sk, input logic ck);
    bus.inp1  = a;
    bus.inp2  = b;
    bus.sum   = s;
    bus.cout  = c;
    bus.sumk  = sk;
    bus.coutk = ck;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0);
    step(); step();

    // reset state
    chk("rst_state", state, 64'd0);
    chk("rst_in_ready", bus.in_ready, 64'd0);
    chk("rst_out_valid", bus.out_valid, 64'd0);
    chk("rst_sample_cnt", sample_cnt, 64'd0);
    chk("rst_mismatch_cnt", mismatch_cnt, 64'd0);
    chk("rst_err_sticky", err_sticky, 64'd0);
    chk("rst_out_sum", bus.out_sum, 64'd0);

    rst = 1'b0; en = 1'b1; step(); en = 1'b0;
    chk("run_state", state, 64'd1);
    chk("run_in_ready", bus.in_ready, 64'd1);
    chk("run_sample_cnt", sample_cnt, 64'd0);

    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_state", state, 64'd0);
    chk("clr_in_ready", bus.in_ready, 64'd0);
    en = 1'b1; step(); en = 1'b0;
    chk("rerun_state", state, 64'd1);

    // normal sample: accept at edge k, visible after edge k+1
    drive(64'h0000_0000_0000_000F, 64'hFFFF_FFFF_FFFF_FFFC,
          64'h0000_0000_0000_000B, 1'b1, 64'h0000_0000_0000_000B, 1'b1);
    bus.in_valid = 1'b1;
    #1;
    chk("norm_in_ready", bus.in_ready, 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk("norm_lat_valid", bus.out_valid, 64'd0);
    step();
    chk("norm_valid", bus.out_valid, 64'd1);
    chk("norm_sum", bus.out_sum, 64'h0000_0000_0000_000B);
    chk("norm_cout", bus.out_cout, 64'd1);
    chk("norm_ovf", bus.out_ovf, 64'd0);
    chk("norm_mism", bus.out_mismatch, 64'd0);
    chk("norm_cnt", sample_cnt, 64'd1);
    step();
    chk("norm_drain", bus.out_valid, 64'd0);

    // back-to-back overflow samples
    drive(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 64'd0, 1'b1);
    bus.in_valid = 1'b1;
    step();
    drive(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("ovf1_sum", bus.out_sum, 64'd0);
    chk("ovf1_cout", bus.out_cout, 64'd1);
    chk("ovf1_ovf", bus.out_ovf, 64'd1);
    chk("ovf1_mism", bus.out_mismatch, 64'd0);
    step();
    chk("ovf2_sum", bus.out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("ovf2_cout", bus.out_cout, 64'd0);
    chk("ovf2_ovf", bus.out_ovf, 64'd1);
    chk("ovf2_mism", bus.out_mismatch, 64'd0);
    chk("ovf2_cnt", sample_cnt, 64'd3);
    step();
    chk("ovf_drain", bus.out_valid, 64'd0);

    // backpressure: two samples fill the pipe, the third must be refused
    bus.out_ready = 1'b0;
    drive(64'h100, 64'h1, 64'h101, 1'b0, 64'h101, 1'b0);
    bus.in_valid = 1'b1;
    #1;
    chk("bp_acc0", bus.in_ready, 64'd1);
    step();
    drive(64'h200, 64'h2, 64'h202, 1'b0, 64'h202, 1'b0);
    #1;
    chk("bp_acc1", bus.in_ready, 64'd1);
    step();
    drive(64'h300, 64'h3, 64'h303, 1'b0, 64'h303, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_stall_valid", bus.out_valid, 64'd1);
      chk("bp_stall_sum", bus.out_sum, 64'h101);
      chk("bp_stall_in_ready", bus.in_ready, 64'd0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rel_sum0", bus.out_sum, 64'h101);
    step();
    chk("bp_rel_valid1", bus.out_valid, 64'd1);
    chk("bp_rel_sum1", bus.out_sum, 64'h202);
    step();
    chk("bp_rel_empty", bus.out_valid, 64'd0);
    chk("bp_cnt", sample_cnt, 64'd5);
    chk("bp_mism_cnt", mismatch_cnt, 64'd0);

    // mismatch on sumk halts; the sample behind it still drains
    drive(64'h1234_5678_9ABC_DEF0, 64'h0EFD_CBA9_8765_4321,
          64'h2132_2222_2222_2211, 1'b0, 64'h2132_2222_2222_2210, 1'b0);
    bus.in_valid = 1'b1;
    step();
    drive(64'd5, 64'd6, 64'd11, 1'b0, 64'd11, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("mm_valid", bus.out_valid, 64'd1);
    chk("mm_sum", bus.out_sum, 64'h2132_2222_2222_2211);
    chk("mm_mism", bus.out_mismatch, 64'd1);
    chk("mm_cnt", mismatch_cnt, 64'd1);
    chk("mm_sticky", err_sticky, 64'd1);
    chk("mm_state", state, 64'd2);
    chk("mm_in_ready", bus.in_ready, 64'd0);
    chk("mm_sample_cnt", sample_cnt, 64'd6);
    step();
    chk("mm_drain_valid", bus.out_valid, 64'd1);
    chk("mm_drain_sum", bus.out_sum, 64'd11);
    chk("mm_drain_mism", bus.out_mismatch, 64'd0);
    chk("mm_drain_cnt", sample_cnt, 64'd7);
    chk("mm_drain_mcnt", mismatch_cnt, 64'd1);
`ifdef ADDER_MON_FAIL_CAPTURE_EN
    chk("ff_a", first_fail_a, 64'h1234_5678_9ABC_DEF0);
    chk("ff_b", first_fail_b, 64'h0EFD_CBA9_8765_4321);
`endif
    en = 1'b1; bus.in_valid = 1'b1;
    step();
    en = 1'b0;
    chk("halt_en_ignored", state, 64'd2);
    chk("halt_in_ready", bus.in_ready, 64'd0);
    chk("halt_empty", bus.out_valid, 64'd0);
    bus.in_valid = 1'b0;

    clr = 1'b1; step(); clr = 1'b0;
    chk("clr2_state", state, 64'd0);
    chk("clr2_sample_cnt", sample_cnt, 64'd0);
    chk("clr2_mismatch_cnt", mismatch_cnt, 64'd0);
    chk("clr2_sticky", err_sticky, 64'd0);
`ifdef ADDER_MON_FAIL_CAPTURE_EN
    chk("clr2_ff_a", first_fail_a, 64'd0);
`endif

    // saturation of the 4-bit sample counter
    en = 1'b1; step(); en = 1'b0;
    drive(64'd1, 64'd2, 64'd3, 1'b0, 64'd3, 1'b0);
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("sat_cnt", sample_cnt, (i - 1 > 15) ? 64'd15 : 64'(i - 1));
    end
    bus.in_valid = 1'b0;
    step();
    chk("sat_final", sample_cnt, 64'd15);
    chk("sat_mism", mismatch_cnt, 64'd0);

    // reset mid-stream discards in-flight samples
    bus.in_valid = 1'b1;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("mid_rst_valid", bus.out_valid, 64'd0);
    chk("mid_rst_state", state, 64'd0);
    chk("mid_rst_cnt", sample_cnt, 64'd0);
    chk("mid_rst_in_ready", bus.in_ready, 64'd0);
    step();
    chk("mid_rst_valid2", bus.out_valid, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
